sdr_init_ref_seq: RTL and testbench
===================================

SDR_INIT_REF_SEQ -- requirements
Module: sdr_init_ref_seq

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- SDR_AW, 12, SDRAM address width.
- INIT_WAIT_CYC, 10000, power-up NOP cycles.
- INIT_REF_NUM, 2, auto-refreshes during init.
- T_RP, 2, precharge-to-command cycles.
- T_RFC, 7, refresh-to-command cycles.
- T_MRD, 2, mode-set-to-command cycles.
- REF_INTERVAL, 780, cycles between refresh obligations.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- sdram_clk, in, 1, sole clock.
- sdram_resetn, in, 1, reset, active-low, synchronous to sdram_clk.
- cfg_mode_reg, in, SDR_AW, value loaded by LOAD MODE REGISTER.
- ref_gnt, in, 1, scheduler: all banks idle, bus released.
- ref_req, out, 1, refresh needed.
- init_done, out, 1, init sequence complete.
- seq_busy, out, 1, sequencer owns command bus.
- sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, out, 1 each, SDRAM command.
- sdr_addr, out, SDR_AW, SDRAM address.
- sdr_ba, out, 2, bank address.

Function
REQ-003 Command encodings {ras_n,cas_n,we_n} SHALL be:
- NOP = 111.
- PRECHARGE = 010.
- AUTO REFRESH = 001.
- LOAD MODE = 000.
- sdr_cs_n is 0 for every command.

REQ-004 Each non-NOP command SHALL last exactly one cycle; every other cycle outputs NOP.

REQ-005 The FSM SHALL step through INIT_WAIT -> INIT_PRE -> INIT_TRP -> INIT_AR -> INIT_TRFC -> (INIT_AR, repeated INIT_REF_NUM times) -> INIT_LMR -> INIT_TMRD -> IDLE.

REQ-006 INIT_WAIT SHALL output NOP for exactly INIT_WAIT_CYC cycles after reset release.

REQ-007 Any PRECHARGE SHALL drive sdr_addr[10]=1 (all banks), other address bits 0 and sdr_ba=0.

REQ-008 LOAD MODE SHALL drive sdr_addr=cfg_mode_reg and sdr_ba=0, with cfg_mode_reg sampled in the same cycle.

REQ-009 The next command after PRECHARGE, AUTO REFRESH or LOAD MODE SHALL be issued exactly T_RP, T_RFC or T_MRD cycles later, respectively.

REQ-010 init_done SHALL rise on entry to IDLE and stay 1 until reset.

REQ-011 seq_busy SHALL be 1 in every state except IDLE and REF_WAIT.

REQ-012 Refresh timer:
- Runs only while init_done=1.
- Counts REF_INTERVAL cycles, then reloads and raises one refresh obligation.

REQ-013 ref_req SHALL be 1 while the pending-refresh count is nonzero; the FSM moves IDLE -> REF_WAIT.

REQ-014 In REF_WAIT, ref_gnt=1 SHALL start the refresh sequence on the next cycle.
- Sequence: REF_PRE -> REF_TRP -> REF_AR -> REF_TRFC -> IDLE.
- ref_req drops in the same cycle as REF_PRE.
- ref_gnt is ignored in every other state.

REQ-015 When a timer expiry and an AUTO REFRESH issue fall in the same cycle, the pending count SHALL be incremented and decremented together, giving a net change of 0.

REQ-016 The pending count SHALL saturate at its maximum; further expiries are dropped without wrapping.

Reset
REQ-017 While sdram_resetn=0 at a sdram_clk edge, the block SHALL hold these values:
- FSM = INIT_WAIT; all counters at 0.
- Command = NOP with sdr_cs_n=1, sdr_addr=0, sdr_ba=0.
- ref_req=0, init_done=0, seq_busy=1.

REQ-018 Reset asserted mid-sequence SHALL abort the sequence in the same edge, and the full init sequence SHALL restart after release.

Configuration
REQ-019 With SDR_REF_BACKLOG_EN defined:
- The pending count is 4 bits and saturates at 8.
- On each grant, the block issues one PRECHARGE, then all pending AUTO REFRESHes back-to-back, each separated by T_RFC.
- It returns to IDLE only when the count reaches 0.

REQ-020 Without SDR_REF_BACKLOG_EN:
- The pending count is a 1-bit flag (saturates at 1).
- Exactly one AUTO REFRESH is issued per grant.

Structure
REQ-021 The following SHALL live in package sdr_seq_pkg:
- The FSM state enum.
- The command encoding constants (CMD_NOP, CMD_PRE, CMD_AR, CMD_LMR).

REQ-022 The refresh interval timer and pending counter SHALL be one sub-module, sdr_ref_timer; the FSM stays in the top-level module.

Verification
Bench parameters: INIT_WAIT_CYC=10, T_RP=2, T_RFC=4, T_MRD=2, INIT_REF_NUM=2, REF_INTERVAL=50, cfg_mode_reg=0x033.

REQ-023 The bench SHALL cover a power-up sequence. Release reset at cycle 0 and expect:
- NOP at cycles 0-9.
- PRECHARGE at cycle 10 with addr[10]=1.
- AUTO REFRESH at cycles 12 and 16.
- LOAD MODE at cycle 20 with sdr_addr=0x033.
- init_done=1 at cycle 22.

REQ-024 The bench SHALL cover refresh with a prompt grant. Hold ref_gnt=1 and expect:
- ref_req rises 50 cycles after init_done.
- PRECHARGE 1 cycle after the grant, AUTO REFRESH 2 cycles later.
- seq_busy low again 4 cycles after the AUTO REFRESH.

REQ-025 The bench SHALL cover a delayed grant. Hold ref_gnt=0 for 120 cycles after ref_req and expect:
- With the macro: 3 AUTO REFRESHes, 4 cycles apart, after the grant.
- Without the macro: exactly 1 AUTO REFRESH.

REQ-026 The bench SHALL cover reset mid-operation. Assert sdram_resetn=0 at cycle 14 during init and expect:
- NOP, init_done=0 at the next edge.
- After release, PRECHARGE again at cycle 10 relative to the release.

REQ-027 The bench SHALL cover a spurious grant. Pulse ref_gnt=1 while in IDLE with nothing pending and expect:
- No command issued.
- seq_busy stays 0.

REQ-028 The bench SHALL cover simultaneous events. Align a timer expiry with an AUTO REFRESH issue (macro on) and expect a net pending-count change of 0.

Source files
------------

// File: rtl/sdr_seq_pkg.sv
// Shared FSM state encoding, SDRAM command encodings and pending-refresh sizing.
// Defining SDR_REF_BACKLOG_EN widens the pending-refresh count to a saturating 0..8 backlog.
package sdr_seq_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_TRP,
    INIT_AR,
    INIT_TRFC,
    INIT_LMR,
    INIT_TMRD,
    IDLE,
    REF_WAIT,
    REF_PRE,
    REF_TRP,
    REF_AR,
    REF_TRFC
  } seq_state_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_AR  = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

`ifdef SDR_REF_BACKLOG_EN
  localparam int PEND_W   = 4;
  localparam int PEND_MAX = 8;
`else
  localparam int PEND_W   = 1;
  localparam int PEND_MAX = 1;
`endif

  // Width of a counter that must reach the largest of the given cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sdr_ref_timer.sv
// Refresh interval timer plus pending-refresh counter; the counter saturates and
// an expiry coinciding with an issued AUTO REFRESH leaves it unchanged.
module sdr_ref_timer
  import sdr_seq_pkg::*;
#(
  parameter int REF_INTERVAL = 780
) (
  input  logic sdram_clk,
  input  logic sdram_resetn,
  input  logic run,
  input  logic ar_issue,
  output logic pend_nz
);

  localparam int                TMR_W    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REF_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  logic [TMR_W-1:0]  tmr;
  logic [PEND_W-1:0] pend;
  logic              expire;
  logic              inc;
  logic              dec;

  assign expire  = run && (tmr == TMR_LAST);
  assign dec     = ar_issue && (pend != '0);
  // A full counter still accepts an expiry when a refresh drains it in the same cycle.
  assign inc     = expire && ((pend != PEND_TOP) || dec);
  assign pend_nz = (pend != '0);

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      tmr  <= '0;
      pend <= '0;
    end else begin
      if (run) tmr <= expire ? '0 : tmr + 1'b1;
      if (inc && !dec)      pend <= pend + 1'b1;
      else if (dec && !inc) pend <= pend - 1'b1;
    end
  end

endmodule

// File: rtl/sdr_init_ref_seq.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// Build option SDR_REF_BACKLOG_EN: drain every pending refresh per grant.
module sdr_init_ref_seq
  import sdr_seq_pkg::*;
#(
  parameter int SDR_AW        = 12,
  parameter int INIT_WAIT_CYC = 10000,
  parameter int INIT_REF_NUM  = 2,
  parameter int T_RP          = 2,
  parameter int T_RFC         = 7,
  parameter int T_MRD         = 2,
  parameter int REF_INTERVAL  = 780
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [SDR_AW-1:0] cfg_mode_reg,
  input  logic              ref_gnt,
  output logic              ref_req,
  output logic              init_done,
  output logic              seq_busy,
  output logic              sdr_cs_n,
  output logic              sdr_ras_n,
  output logic              sdr_cas_n,
  output logic              sdr_we_n,
  output logic [SDR_AW-1:0] sdr_addr,
  output logic [1:0]        sdr_ba
);

  localparam int CNT_W = cnt_width(INIT_WAIT_CYC, T_RP, T_RFC, T_MRD);
  localparam int AR_W  = (INIT_REF_NUM > 0) ? $clog2(INIT_REF_NUM + 1) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [AR_W-1:0]   ar_cnt;
  logic [AR_W-1:0]   ar_cnt_nxt;
  logic              init_done_r;
  logic              cmd_en;
  logic              pend_nz;
  logic [2:0]        cmd;
  logic [SDR_AW-1:0] addr_c;

  sdr_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .sdram_clk    (sdram_clk),
    .sdram_resetn (sdram_resetn),
    .run          (init_done_r),
    .ar_issue     (state == REF_AR),
    .pend_nz      (pend_nz)
  );

  // cmd_en keeps chip-select deasserted while the block is held in reset.
  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      state       <= INIT_WAIT;
      cnt         <= '0;
      ar_cnt      <= '0;
      init_done_r <= 1'b0;
      cmd_en      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ar_cnt <= ar_cnt_nxt;
      cmd_en <= 1'b1;
      if (state_nxt == IDLE) init_done_r <= 1'b1;
    end
  end

  // Command states preload cnt with 1 so each wait state exits after T_x-1 cycles.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    ar_cnt_nxt = ar_cnt;
    case (state)
      INIT_WAIT: begin
        if (cnt == CNT_W'(INIT_WAIT_CYC)) state_nxt = INIT_PRE;
        else                              cnt_nxt   = cnt + 1'b1;
      end
      INIT_PRE: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = INIT_TRP;
      end
      INIT_TRP: begin
        if (cnt >= CNT_W'(T_RP - 1)) state_nxt = INIT_AR;
        else                         cnt_nxt   = cnt + 1'b1;
      end
      INIT_AR: begin
        cnt_nxt    = CNT_W'(1);
        ar_cnt_nxt = ar_cnt + 1'b1;
        state_nxt  = INIT_TRFC;
      end
      INIT_TRFC: begin
        if (cnt >= CNT_W'(T_RFC - 1))
          state_nxt = (ar_cnt >= AR_W'(INIT_REF_NUM)) ? INIT_LMR : INIT_AR;
        else
          cnt_nxt = cnt + 1'b1;
      end
      INIT_LMR: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = INIT_TMRD;
      end
      INIT_TMRD: begin
        if (cnt >= CNT_W'(T_MRD - 1)) begin
          state_nxt  = IDLE;
          ar_cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (pend_nz) state_nxt = REF_WAIT;
      end
      REF_WAIT: begin
        if (ref_gnt) state_nxt = REF_PRE;
      end
      REF_PRE: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = REF_TRP;
      end
      REF_TRP: begin
        if (cnt >= CNT_W'(T_RP - 1)) state_nxt = REF_AR;
        else                         cnt_nxt   = cnt + 1'b1;
      end
      REF_AR: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = REF_TRFC;
      end
      REF_TRFC: begin
        if (cnt >= CNT_W'(T_RFC - 1)) begin
`ifdef SDR_REF_BACKLOG_EN
          state_nxt = pend_nz ? REF_AR : IDLE;
`else
          state_nxt = IDLE;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = INIT_WAIT;
    endcase
  end

  always_comb begin
    cmd      = CMD_NOP;
    addr_c   = '0;
    seq_busy = 1'b1;
    case (state)
      INIT_PRE, REF_PRE: begin
        cmd        = CMD_PRE;
        addr_c[10] = 1'b1;
      end
      INIT_AR, REF_AR: cmd = CMD_AR;
      INIT_LMR: begin
        cmd    = CMD_LMR;
        addr_c = cfg_mode_reg;
      end
      IDLE, REF_WAIT: seq_busy = 1'b0;
      default: ;
    endcase
  end

  // The request is withdrawn once the sequencer has taken the bus for the refresh.
  assign ref_req                         = pend_nz && ((state == IDLE) || (state == REF_WAIT));
  assign init_done                       = init_done_r;
  assign sdr_cs_n                        = ~cmd_en;
  assign {sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd;
  assign sdr_addr                        = addr_c;
  assign sdr_ba                          = 2'b00;

endmodule

// File: tb/tb_sdr_init_ref_seq.sv
// Directed bench for sdr_init_ref_seq: power-up, refresh grants, backlog, reset abort.
module tb_sdr_init_ref_seq;

  localparam int AW = 12;
  localparam logic [2:0] P_NOP = 3'b111;
  localparam logic [2:0] P_PRE = 3'b010;
  localparam logic [2:0] P_AR  = 3'b001;
  localparam logic [2:0] P_LMR = 3'b000;

  typedef struct packed {
    logic          cs_n;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [1:0]    ba;
    logic          done;
    logic          busy;
    logic          req;
  } out_t;

  typedef struct packed {
    logic gnt;
    out_t exp;
  } vec_t;

  localparam out_t RST_EXP = {1'b1, 3'b111, 12'h000, 2'b00, 1'b0, 1'b1, 1'b0};

  logic          sdram_clk = 1'b0;
  logic          sdram_resetn;
  logic [AW-1:0] cfg_mode_reg;
  logic          ref_gnt;
  logic          ref_req, init_done, seq_busy;
  logic          sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [AW-1:0] sdr_addr;
  logic [1:0]    sdr_ba;
  out_t          cur;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  always #5 sdram_clk = ~sdram_clk;

  sdr_init_ref_seq #(
    .SDR_AW        (AW),
    .INIT_WAIT_CYC (10),
    .INIT_REF_NUM  (2),
    .T_RP          (2),
    .T_RFC         (4),
    .T_MRD         (2),
    .REF_INTERVAL  (50)
  ) dut (
    .sdram_clk    (sdram_clk),
    .sdram_resetn (sdram_resetn),
    .cfg_mode_reg (cfg_mode_reg),
    .ref_gnt      (ref_gnt),
    .ref_req      (ref_req),
    .init_done    (init_done),
    .seq_busy     (seq_busy),
    .sdr_cs_n     (sdr_cs_n),
    .sdr_ras_n    (sdr_ras_n),
    .sdr_cas_n    (sdr_cas_n),
    .sdr_we_n     (sdr_we_n),
    .sdr_addr     (sdr_addr),
    .sdr_ba       (sdr_ba)
  );

  assign cur = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
                init_done, seq_busy, ref_req};

  function automatic out_t mk(input logic [2:0] c, input logic [AW-1:0] a,
                              input logic d, input logic b, input logic q);
    mk = {1'b0, c, a, 2'b00, d, b, q};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
  endtask

  task automatic step();
    @(negedge sdram_clk);
    cyc++;
  endtask

  task automatic wait_req(output int r);
    r = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ref_req === 1'b1) begin
        r = cyc;
        break;
      end
    end
  endtask

  vec_t tv[0:22];
  vec_t tp[0:8];

  initial begin
    int r, r2, r3, bad, n_ar, first_ar, last_ar, busy_low, req_at;

    // power-up expectations, cycle 0 = first cycle after reset release
    for (int i = 0; i <= 22; i++) tv[i] = {1'b0, mk(P_NOP, 12'h000, 1'b0, 1'b1, 1'b0)};
    tv[10].exp = mk(P_PRE, 12'h400, 1'b0, 1'b1, 1'b0);
    tv[12].exp = mk(P_AR,  12'h000, 1'b0, 1'b1, 1'b0);
    tv[16].exp = mk(P_AR,  12'h000, 1'b0, 1'b1, 1'b0);
    tv[20].exp = mk(P_LMR, 12'h033, 1'b0, 1'b1, 1'b0);
    tv[22].exp = mk(P_NOP, 12'h000, 1'b1, 1'b0, 1'b0);

    // prompt grant, offsets from the cycle ref_req is first seen
    tp[0] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b0, 1'b1)};
    tp[1] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b0, 1'b1)};
    tp[2] = {1'b1, mk(P_PRE, 12'h400, 1'b1, 1'b1, 1'b0)};
    tp[3] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b1, 1'b0)};
    tp[4] = {1'b1, mk(P_AR,  12'h000, 1'b1, 1'b1, 1'b0)};
    tp[5] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b1, 1'b0)};
    tp[6] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b1, 1'b0)};
    tp[7] = {1'b1, mk(P_NOP, 12'h000, 1'b1, 1'b1, 1'b0)};
    tp[8] = {1'b0, mk(P_NOP, 12'h000, 1'b1, 1'b0, 1'b0)};

    sdram_resetn = 1'b0;
    ref_gnt      = 1'b0;
    cfg_mode_reg = 12'h033;
    repeat (3) @(negedge sdram_clk);
    chk("reset_state", cur, RST_EXP);

    // power-up sequence
    sdram_resetn = 1'b1;
    cyc = -1;
    for (int c = 0; c <= 22; c++) begin
      step();
      chk($sformatf("init_c%0d", c), cur, tv[c].exp);
      ref_gnt = tv[c].gnt;
    end

    // spurious grant pulses in IDLE with nothing pending
    bad = 0;
    for (int c = 23; c <= 40; c++) begin
      step();
      if (cur.cmd !== P_NOP || cur.cs_n !== 1'b0 || cur.busy !== 1'b0 || cur.req !== 1'b0) bad++;
      ref_gnt = (c % 2 == 1);
    end
    chk("spurious_gnt_bad_cycles", bad, 0);

    // prompt grant
    ref_gnt = 1'b1;
    wait_req(r);
    chk("prompt_req_cycle", r, 72);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) step();
      chk($sformatf("prompt_off%0d", k), cur, tp[k].exp);
      ref_gnt = tp[k].gnt;
    end

    // delayed grant: backlog builds for 120 cycles
    wait_req(r2);
    chk("delayed_req_cycle", r2, r + 50);
    bad = 0;
    req_at = 0;
    for (int k = 1; k <= 120; k++) begin
      step();
      if (cur.cmd !== P_NOP) bad++;
      if (k == 119) req_at = int'(ref_req);
    end
    chk("delayed_wait_no_cmd", bad, 0);
    chk("delayed_req_held", req_at, 1);
    ref_gnt = 1'b1;
    n_ar = 0; first_ar = -1; last_ar = -1; busy_low = -1;
    for (int k = 121; k <= 145; k++) begin
      step();
      if (k == 122) ref_gnt = 1'b0;
      if (cur.cmd === P_AR) begin
        n_ar++;
        if (first_ar < 0) first_ar = k;
        last_ar = k;
      end
      if (first_ar >= 0 && seq_busy === 1'b0 && busy_low < 0) busy_low = k;
    end
    chk("delayed_first_ar", first_ar, 123);
`ifdef SDR_REF_BACKLOG_EN
    chk("delayed_ar_count", n_ar, 3);
    chk("delayed_last_ar", last_ar, 131);
    chk("delayed_busy_low", busy_low, 135);
`else
    chk("delayed_ar_count", n_ar, 1);
    chk("delayed_last_ar", last_ar, 123);
    chk("delayed_busy_low", busy_low, 127);
`endif

    // timer expiry aligned with the AUTO REFRESH cycle
    wait_req(r3);
    chk("collide_req_cycle", r3, r2 + 150);
    n_ar = 0; first_ar = -1; last_ar = -1; busy_low = -1; req_at = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (cur.cmd === P_AR) begin
        n_ar++;
        if (first_ar < 0) first_ar = k;
        last_ar = k;
      end
      if (first_ar >= 0 && seq_busy === 1'b0 && busy_low < 0) begin
        busy_low = k;
        req_at   = int'(ref_req);
      end
      ref_gnt = (k == 46);
    end
    chk("collide_first_ar", first_ar, 49);
`ifdef SDR_REF_BACKLOG_EN
    chk("collide_ar_count", n_ar, 2);
    chk("collide_last_ar", last_ar, 53);
    chk("collide_busy_low", busy_low, 57);
    chk("collide_req_after", req_at, 0);
`else
    chk("collide_ar_count", n_ar, 1);
    chk("collide_busy_low", busy_low, 53);
    chk("collide_req_after", req_at, 1);
`endif

    // reset from IDLE, then abort a fresh init part-way
    ref_gnt      = 1'b0;
    sdram_resetn = 1'b0;
    step();
    step();
    chk("reset_after_init", cur, RST_EXP);
    sdram_resetn = 1'b1;
    cyc = -1;
    for (int c = 0; c <= 14; c++) step();
    chk("abort_pre_c14", cur, mk(P_NOP, 12'h000, 1'b0, 1'b1, 1'b0));
    sdram_resetn = 1'b0;
    step();
    chk("abort_next_edge", cur, RST_EXP);
    sdram_resetn = 1'b1;
    cyc = -1;
    for (int c = 0; c <= 12; c++) begin
      step();
      if (c == 9)  chk("restart_c9",  cur, mk(P_NOP, 12'h000, 1'b0, 1'b1, 1'b0));
      if (c == 10) chk("restart_c10", cur, mk(P_PRE, 12'h400, 1'b0, 1'b1, 1'b0));
      if (c == 12) chk("restart_c12", cur, mk(P_AR,  12'h000, 1'b0, 1'b1, 1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
